// File: rtl/glip_uart_pkg.sv
// Shared GLIP UART framing constants and FSM encodings.
// Used by both the host-side and the device-side control blocks.
package glip_uart_pkg;

    localparam logic [7:0] Esc          = 8'hFE;
    localparam logic       MsgCreditMsb = 1'b1;
    localparam logic       MsgResetMsb  = 1'b0;

    typedef enum logic [2:0] {
        TxIdle,
        TxData,
        TxEsc2,
        TxMsg0,
        TxMsg1,
        TxMsg2
    } tx_state_t;

    typedef enum logic [1:0] {
        RxNormal,
        RxEsc,
        RxCredLo
    } rx_state_t;

    function automatic logic [7:0] reset_msg(input logic com, input logic lgc);
        return {MsgResetMsb, 5'b0, com, lgc};
    endfunction

    function automatic logic [7:0] credit_msg_hi(input logic [14:0] c);
        return {MsgCreditMsb, c[14:8]};
    endfunction

endpackage

// File: rtl/glip_uart_host_control_rx_parse.sv
// Host-side RX parser: unescapes payload, extracts credit messages, flags bad escapes.
// Note: module name is glip_uart_host_rx_parse.
module glip_uart_host_rx_parse
    import glip_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        reinit,
    input  logic [7:0]  rx_in_data,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    output logic [7:0]  rx_out_data,
    output logic        rx_out_valid,
    input  logic        rx_out_ready,
    output logic        credit_valid,
    output logic [14:0] credit_value,
    output logic        proto_error
);

    rx_state_t  state;
    logic [6:0] cred_hi;
    logic       take;

    // The output register frees up in the same cycle its byte is taken downstream.
    assign rx_in_ready = !rx_out_valid || rx_out_ready;
    assign take        = rx_in_valid && rx_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RxNormal;
            cred_hi      <= '0;
            rx_out_data  <= '0;
            rx_out_valid <= 1'b0;
            credit_valid <= 1'b0;
            credit_value <= '0;
            proto_error  <= 1'b0;
        end else if (reinit) begin
            state        <= RxNormal;
            cred_hi      <= '0;
            rx_out_data  <= '0;
            rx_out_valid <= 1'b0;
            credit_valid <= 1'b0;
            credit_value <= '0;
            proto_error  <= 1'b0;
        end else begin
            credit_valid <= 1'b0;
            proto_error  <= 1'b0;
            if (rx_out_ready) begin
                rx_out_valid <= 1'b0;
            end
            if (take) begin
                unique case (state)
                    RxNormal: begin
                        if (rx_in_data == Esc) begin
                            state <= RxEsc;
                        end else begin
                            rx_out_data  <= rx_in_data;
                            rx_out_valid <= 1'b1;
                        end
                    end
                    RxEsc: begin
                        if (rx_in_data == Esc) begin
                            rx_out_data  <= Esc;
                            rx_out_valid <= 1'b1;
                            state        <= RxNormal;
                        end else if (rx_in_data[7] == MsgCreditMsb) begin
                            cred_hi <= rx_in_data[6:0];
                            state   <= RxCredLo;
                        end else begin
                            proto_error <= 1'b1;
                            state       <= RxNormal;
                        end
                    end
                    RxCredLo: begin
                        credit_valid <= 1'b1;
                        credit_value <= {cred_hi, rx_in_data};
                        state        <= RxNormal;
                    end
                    default: state <= RxNormal;
                endcase
            end
        end
    end

endmodule

// File: rtl/glip_uart_host_control.sv
// Host-side GLIP UART control: TX framing with escape/credit/reset messages,
// device-credit accounting and host-FIFO credit grants.
module glip_uart_host_control
    import glip_uart_pkg::*;
#(
    parameter int unsigned HOST_FIFO_CREDIT = 16,
    parameter int unsigned CREDIT_WIDTH     = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_in_data,
    input  logic       tx_in_valid,
    output logic       tx_in_ready,
    output logic [7:0] tx_out_data,
    output logic       tx_out_enable,
    input  logic       tx_out_done,
    input  logic [7:0] rx_in_data,
    input  logic       rx_in_valid,
    output logic       rx_in_ready,
    output logic [7:0] rx_out_data,
    output logic       rx_out_valid,
    input  logic       rx_out_ready,
    input  logic       logic_rst_req,
    input  logic       com_rst_req,
    output logic       error
);

    localparam logic [14:0] FullGrant = 15'(HOST_FIFO_CREDIT);
    localparam logic [14:0] HalfGrant = 15'(HOST_FIFO_CREDIT / 2);
    localparam int unsigned SumWidth  = ((CREDIT_WIDTH > 15) ? CREDIT_WIDTH : 15) + 2;
    localparam logic [CREDIT_WIDTH-1:0] CreditMax = '1;

    tx_state_t               state;
    logic [7:0]              msg_b1, msg_b2;
    logic                    msg_long, esc_pend;
    logic [CREDIT_WIDTH-1:0] device_credit;
    logic                    grant_pending;
    logic [14:0]             grant_amt, grant_cnt;
    logic                    pend_logic, pend_com;

    logic                    credit_valid, proto_error, reinit;
    logic [14:0]             credit_value;
    logic                    rst_pend, take_rst, take_grant, consume, deliver, grant_new;
    logic                    overflow;
    logic [SumWidth-1:0]     credit_sum;

    assign rst_pend    = pend_logic || pend_com;
    assign take_rst    = (state == TxIdle) && rst_pend;
    assign take_grant  = (state == TxIdle) && !rst_pend && grant_pending;
    assign tx_in_ready = (state == TxIdle) && !rst_pend && !grant_pending &&
                         (device_credit != '0);
    assign consume     = tx_in_valid && tx_in_ready;
    assign deliver     = rx_out_valid && rx_out_ready;
    assign grant_new   = (grant_cnt == '0);
    // Completion of a com reset message restarts the whole link state.
    assign reinit      = (state == TxMsg1) && tx_out_done && !msg_long && msg_b1[1];

    assign credit_sum = SumWidth'(device_credit)
                      + (credit_valid ? SumWidth'(credit_value) : '0)
                      - SumWidth'(consume);
    assign overflow   = credit_sum > SumWidth'(CreditMax);

    glip_uart_host_rx_parse u_rx_parse (
        .clk          (clk),
        .rst          (rst),
        .reinit       (reinit),
        .rx_in_data   (rx_in_data),
        .rx_in_valid  (rx_in_valid),
        .rx_in_ready  (rx_in_ready),
        .rx_out_data  (rx_out_data),
        .rx_out_valid (rx_out_valid),
        .rx_out_ready (rx_out_ready),
        .credit_valid (credit_valid),
        .credit_value (credit_value),
        .proto_error  (proto_error)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= TxIdle;
            tx_out_data   <= '0;
            tx_out_enable <= 1'b0;
            msg_b1        <= '0;
            msg_b2        <= '0;
            msg_long      <= 1'b0;
            esc_pend      <= 1'b0;
        end else begin
            unique case (state)
                TxIdle: begin
                    if (take_rst) begin
                        tx_out_data   <= Esc;
                        tx_out_enable <= 1'b1;
                        msg_b1        <= reset_msg(pend_com, pend_logic);
                        msg_long      <= 1'b0;
                        state         <= TxMsg0;
                    end else if (take_grant) begin
                        tx_out_data   <= Esc;
                        tx_out_enable <= 1'b1;
                        msg_b1        <= credit_msg_hi(grant_amt);
                        msg_b2        <= grant_amt[7:0];
                        msg_long      <= 1'b1;
                        state         <= TxMsg0;
                    end else if (consume) begin
                        tx_out_data   <= tx_in_data;
                        tx_out_enable <= 1'b1;
                        esc_pend      <= (tx_in_data == Esc);
                        state         <= TxData;
                    end
                end
                TxData: begin
                    if (tx_out_done) begin
                        if (esc_pend) begin
                            tx_out_data <= Esc;
                            state       <= TxEsc2;
                        end else begin
                            tx_out_enable <= 1'b0;
                            state         <= TxIdle;
                        end
                    end
                end
                TxMsg0: begin
                    if (tx_out_done) begin
                        tx_out_data <= msg_b1;
                        state       <= TxMsg1;
                    end
                end
                TxMsg1: begin
                    if (tx_out_done) begin
                        if (msg_long) begin
                            tx_out_data <= msg_b2;
                            state       <= TxMsg2;
                        end else begin
                            tx_out_enable <= 1'b0;
                            state         <= TxIdle;
                        end
                    end
                end
                TxEsc2, TxMsg2: begin
                    if (tx_out_done) begin
                        tx_out_enable <= 1'b0;
                        state         <= TxIdle;
                    end
                end
                default: state <= TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            device_credit <= '0;
            grant_pending <= 1'b1;
            grant_amt     <= FullGrant;
            grant_cnt     <= HalfGrant;
            pend_logic    <= 1'b0;
            pend_com      <= 1'b0;
            error         <= 1'b0;
        end else begin
            // Requests landing while a reset message starts are kept for the next one.
            pend_logic <= (pend_logic && !take_rst) || logic_rst_req;
            pend_com   <= (pend_com && !take_rst) || com_rst_req;
            if (proto_error || overflow) begin
                error <= 1'b1;
            end
            if (reinit) begin
                device_credit <= '0;
                grant_pending <= 1'b1;
                grant_amt     <= FullGrant;
                grant_cnt     <= HalfGrant;
            end else begin
                device_credit <= overflow ? CreditMax : credit_sum[CREDIT_WIDTH-1:0];
                grant_cnt     <= (grant_new ? HalfGrant : grant_cnt) - 15'(deliver);
                grant_pending <= (grant_pending && !take_grant) || grant_new;
                grant_amt     <= (take_grant ? '0 : grant_amt) + (grant_new ? HalfGrant : '0);
            end
        end
    end

endmodule

// File: doc/glip_uart_host_control.md
GLIP_UART_HOST_CONTROL -- requirements
Module: glip_uart_host_control

Interface
REQ-001 SHALL have parameter HOST_FIFO_CREDIT, default 16, meaning the depth of the host receive FIFO granted to the device (even, 2..32767).
REQ-002 SHALL have parameter CREDIT_WIDTH, default 15, meaning the width of the device-credit counter and of credit fields.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have ports tx_in_data/tx_in_valid/tx_in_ready, input/input/output, 8/1/1, meaning host payload bytes to the device (valid/ready).
REQ-006 SHALL have ports tx_out_data/tx_out_enable/tx_out_done, output/output/input, 8/1/1, meaning the byte to the UART transmitter; done is a 1-cycle pulse when the byte has been sent.
REQ-007 SHALL have ports rx_in_data/rx_in_valid/rx_in_ready, input/input/output, 8/1/1, meaning raw bytes from the UART receiver.
REQ-008 SHALL have ports rx_out_data/rx_out_valid/rx_out_ready, output/output/input, 8/1/1, meaning decoded device payload bytes.
REQ-009 SHALL have ports logic_rst_req/com_rst_req, input/input, 1/1, meaning single-cycle requests to send a reset message.
REQ-010 SHALL have port error, output, 1, meaning a sticky protocol error.

Function
REQ-011 Wire format SHALL be: escape 0xFE; payload 0xFE sent as FE FE; credit message FE,{1,c[14:8]},c[7:0]; reset message FE,{6'b0,com,logic}.
REQ-012 The TX FSM SHALL have states IDLE, DATA, ESC2, MSG0, MSG1, MSG2; one byte is presented per state, with tx_out_enable held high until tx_out_done.
REQ-013 The TX priority at IDLE SHALL be pending reset message > pending credit grant > payload; a multi-byte sequence is never interleaved.
REQ-014 Payload SHALL be accepted (tx_in_ready=1 for one cycle) only in IDLE with device_credit>0; device_credit decrements by 1 per accepted byte, and an escaped byte costs 1.
REQ-015 The RX parser SHALL have states NORMAL, ESC, CRED_LO. A non-0xFE byte in NORMAL is payload. FE moves to ESC. In ESC: FE is payload 0xFE; MSB=1 captures the high bits and moves to CRED_LO; MSB=0 is an error and returns to NORMAL. In CRED_LO the byte completes the credit, which is added to device_credit.
REQ-016 rx_out SHALL use a single output register; rx_in_ready=0 while it holds unaccepted data; an rx_in byte is consumed on rx_in_valid&rx_in_ready.
REQ-017 A credit add and a payload consume in the same cycle SHALL both take effect (net add-1).
REQ-018 A credit add overflowing CREDIT_WIDTH SHALL saturate at all-ones and set error.
REQ-019 After reset, a grant of HOST_FIFO_CREDIT SHALL be pending, and grant_cnt is loaded with HOST_FIFO_CREDIT/2.
REQ-020 Each payload byte delivered on rx_out SHALL decrement grant_cnt; at 0 a grant of HOST_FIFO_CREDIT/2 becomes pending and grant_cnt reloads to HOST_FIFO_CREDIT/2.
REQ-021 A payload byte received while grant_cnt=0 in the same cycle as the reload SHALL be counted against the reloaded value.
REQ-022 logic_rst_req and com_rst_req SHALL set sticky pending bits, merged into one reset message; a request arriving during transmission is sent next.
REQ-023 When a message with com=1 completes, device_credit, grant state and the RX parser SHALL be reinitialised as after reset; error is not cleared.

Reset
REQ-024 On rst, the block SHALL set: TX FSM to IDLE; RX parser to NORMAL; tx_out_enable=0; tx_out_data=0; tx_in_ready=0; rx_out_valid=0; rx_out_data=0; rx_in_ready=1; device_credit=0; error=0; reset requests cleared.
REQ-025 Asserting rst mid-sequence SHALL abandon the partial message; no further tx_out byte is presented until after release.

Structure
REQ-026 The escape byte, message MSB codes and the FSM state encodings SHALL live in a shared glip_uart package, also used by the device-side control.
REQ-027 The RX parser SHALL be a sub-module, glip_uart_host_rx_parse; TX framing and credit/grant logic stay in the top.

Verification
REQ-028 Scenario: after reset with done acknowledging every byte -> tx_out emits FE,0x80,0x10; tx_in_ready stays 0 until credit arrives.
REQ-029 Scenario: rx FE,0x80,0x03 then tx bytes 0x11,0xFE,0x22,0x33 offered -> tx_out sends 11,FE,FE,22; 0x33 stalls.
REQ-030 Scenario: rx 0x41,FE,FE,0x42 with rx_out_ready=1 -> rx_out gives 41,FE,42; error=0.
REQ-031 Scenario: 8 payload bytes delivered on rx_out -> grant FE,0x80,0x08 sent exactly once.
REQ-032 Scenario: com_rst_req during payload 0xFE escape -> FE,FE completes, then FE,0x02; device_credit=0 afterwards.
REQ-033 Scenario: rx FE,0x05 -> error=1, sticky until rst.
